// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot address encoder: error classes, default
// line count and the output-stage state type.
package onehot_pkg;

  localparam int DEFAULT_LINES = 4;

  localparam logic [1:0] ERR_OK           = 2'b00;
  localparam logic [1:0] ERR_NONE_HOT     = 2'b01;
  localparam logic [1:0] ERR_MULTI_HOT    = 2'b10;
  localparam logic [1:0] ERR_HOT_DISABLED = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/onehot_classify.sv
// Combinational classifier: LSB-priority index of the set lines, popcount
// flags and the error class for a line/enable pair.
module onehot_classify
  import onehot_pkg::*;
#(
  parameter int LINES  = DEFAULT_LINES,
  parameter int ADDR_W = $clog2(LINES)
) (
  input  logic [LINES-1:0]  line,
  input  logic              enable,
  output logic [ADDR_W-1:0] idx,
  output logic              none_hot,
  output logic              multi_hot,
  output logic [1:0]        err_code
);

  localparam int CNT_W = $clog2(LINES + 1);

  logic [CNT_W-1:0] pop;

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx = '0;
    pop = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (line[i]) idx = ADDR_W'(i);
    end
    for (int i = 0; i < LINES; i++) begin
      pop = pop + CNT_W'(line[i]);
    end
  end

  assign none_hot  = (pop == '0);
  assign multi_hot = (pop > CNT_W'(1));

  always_comb begin
    err_code = ERR_OK;
    if (enable) begin
      if (none_hot)       err_code = ERR_NONE_HOT;
      else if (multi_hot) err_code = ERR_MULTI_HOT;
    end else if (!none_hot) begin
      err_code = ERR_HOT_DISABLED;
    end
  end

endmodule

// File: rtl/onehot_addr_encoder.sv
// Registered one-hot to binary encoder with valid/ready on both sides, beat
// classification and a saturating error counter.
module onehot_addr_encoder
  import onehot_pkg::*;
#(
  parameter int LINES     = DEFAULT_LINES,
  parameter int ADDR_W    = $clog2(LINES),
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LINES-1:0]     line,
  input  logic                 enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    address,
  output logic                 enable_o,
  output logic [1:0]           err_code,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
  output out_state_e           state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high. in_valid/out_valid are not withdrawn by this block once raised;
  // in_ready depends combinationally on out_ready so one result can drain and
  // the next be captured in the same cycle.

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  out_state_e        state_q, state_d;
  logic              accept;
  logic              beat_err;
  logic [ADDR_W-1:0] cls_idx;
  logic              cls_none;
  logic              cls_multi;
  logic [1:0]        cls_code;

  onehot_classify #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_classify (
    .line      (line),
    .enable    (enable),
    .idx       (cls_idx),
    .none_hot  (cls_none),
    .multi_hot (cls_multi),
    .err_code  (cls_code)
  );

  // Held low during reset so nothing is taken while the stage is cleared.
  assign in_ready  = rst_n & ((state_q == ST_EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_FULL);
  assign state_dbg = state_q;

  // Enabled beats err unless exactly one line is hot; idle beats err on any hot line.
  assign beat_err = enable ? (cls_none | cls_multi) : ~cls_none;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address  <= '0;
      enable_o <= 1'b0;
      err_code <= ERR_OK;
    end else if (accept) begin
      address  <= cls_idx;
      enable_o <= enable;
      err_code <= cls_code;
    end
  end

  // A clear coinciding with an erroring beat keeps that beat's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= (accept && beat_err) ? ERR_CNT_W'(1) : '0;
    end else if (accept && beat_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_addr_encoder.sv
// Bench for onehot_addr_encoder: table vectors, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_onehot_addr_encoder;
  import onehot_pkg::*;

  localparam int LINES  = 4;
  localparam int ADDR_W = 2;
  localparam int W      = ADDR_W + 3;

  // clock / reset / inputs
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [LINES-1:0] line = '0;
  logic             enable = 1'b0;
  logic             out_ready = 1'b0;
  logic             err_clr = 1'b0;

  // default-width instance
  logic              in_ready, out_valid, enable_o;
  logic [ADDR_W-1:0] address;
  logic [1:0]        err_code;
  logic [7:0]        err_count;
  out_state_e        state_dbg;

  // narrow-counter instance
  logic              s_in_ready, s_out_valid, s_enable_o;
  logic [ADDR_W-1:0] s_address;
  logic [1:0]        s_err_code;
  logic [1:0]        s_err_count;
  out_state_e        s_state_dbg;

  always #5 clk = ~clk;

  onehot_addr_encoder #(.LINES(LINES), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .line(line), .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .address(address), .enable_o(enable_o), .err_code(err_code),
    .err_clr(err_clr), .err_count(err_count), .state_dbg(state_dbg)
  );

  onehot_addr_encoder #(.LINES(LINES), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .line(line), .enable(enable), .out_valid(s_out_valid), .out_ready(out_ready),
    .address(s_address), .enable_o(s_enable_o), .err_code(s_err_code),
    .err_clr(err_clr), .err_count(s_err_count), .state_dbg(s_state_dbg)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: {address, enable, class} from popcount and lowest set bit.
  function automatic logic [W-1:0] model(input logic [LINES-1:0] ln, input logic en);
    int p = $countones(ln);
    int v = int'(ln);
    int a = 0;
    logic [1:0] c;
    if (v != 0) a = $clog2(v & -v);
    if (en) c = (p == 1) ? ERR_OK : ((p == 0) ? ERR_NONE_HOT : ERR_MULTI_HOT);
    else    c = (p == 0) ? ERR_OK : ERR_HOT_DISABLED;
    return {ADDR_W'(a), en, c};
  endfunction

  task automatic check_outputs();
    logic [W-1:0] f;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("out_valid_sat", s_out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      f = exp_q[0];
      check("address", address, f[W-1:3]);
      check("enable_o", enable_o, f[2]);
      check("err_code", err_code, f[1:0]);
      check("address_sat", s_address, f[W-1:3]);
      check("err_code_sat", s_err_code, f[1:0]);
    end
    check("err_count", err_count, exp_cnt8);
    check("err_count_sat", s_err_count, exp_cnt2);
  endtask

  // driver: one clock cycle of stimulus, called at posedge+1
  task automatic cycle(input logic v, input logic [LINES-1:0] ln, input logic en,
                       input logic ordy, input logic clr);
    logic exp_rdy, acc, drain, err;
    logic [W-1:0] r;
    in_valid = v; line = ln; enable = en; out_ready = ordy; err_clr = clr;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", in_ready, exp_rdy);
    check("in_ready_sat", s_in_ready, exp_rdy);
    acc   = v && exp_rdy;
    drain = (exp_q.size() != 0) && ordy;
    r     = model(ln, en);
    err   = (r[1:0] != ERR_OK);
    @(posedge clk);
    #1;
    if (drain) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(r);
    if (clr) begin
      exp_cnt8 = (acc && err) ? 1 : 0;
      exp_cnt2 = (acc && err) ? 1 : 0;
    end else if (acc && err) begin
      exp_cnt8 = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
      exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
    end
    check_outputs();
  endtask

  typedef struct {
    logic [LINES-1:0]  line;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        code;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    tbl[0] = '{4'b0001, 1'b1, 2'd0, ERR_OK};
    tbl[1] = '{4'b0010, 1'b1, 2'd1, ERR_OK};
    tbl[2] = '{4'b0100, 1'b1, 2'd2, ERR_OK};
    tbl[3] = '{4'b1000, 1'b1, 2'd3, ERR_OK};
    tbl[4] = '{4'b0000, 1'b1, 2'd0, ERR_NONE_HOT};
    tbl[5] = '{4'b0110, 1'b1, 2'd1, ERR_MULTI_HOT};
    tbl[6] = '{4'b1000, 1'b0, 2'd3, ERR_HOT_DISABLED};
    tbl[7] = '{4'b0000, 1'b0, 2'd0, ERR_OK};

    // reset held with a pending beat
    rst_n = 1'b0; in_valid = 1'b1; line = 4'b0001; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_address", address, 0);
    check("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("release_in_ready", in_ready, 1);

    // table sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].line, tbl[i].en, 1'b1, 1'b0);
      check("tbl_address", address, tbl[i].addr);
      check("tbl_err_code", err_code, tbl[i].code);
      check("tbl_enable_o", enable_o, tbl[i].en);
      if (i == 3) check("tbl_legal_count", err_count, 0);
    end
    check("tbl_err_count", err_count, 3);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // backpressure: hold 0100 for 5 cycles, then drain + accept together
    cycle(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
      check("bp_in_ready", in_ready, 0);
      check("bp_address_held", address, 2);
    end
    cycle(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
    check("bp_new_address", address, 0);
    check("bp_out_valid", out_valid, 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // counter saturation on the 2-bit instance, then clear with an error beat
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("clr_only", err_count, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0011, 1'b1, 1'b1, 1'b0);
    check("sat_count", s_err_count, 3);
    check("wide_count", err_count, 5);
    cycle(1'b1, 4'b1100, 1'b1, 1'b1, 1'b1);
    check("clr_with_err_sat", s_err_count, 1);
    check("clr_with_err", err_count, 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // reset while FULL
    cycle(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_count", err_count, 0);
    exp_q.delete();
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // push the wide counter into saturation
    for (int i = 0; i < 320; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 15) | 4'b0011), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    check("wide_saturated", err_count, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
